// File: rtl/rom_access_arbiter_pkg.sv
// Shared types for the ROM access arbiter: FSM state encoding and the
// state-to-grant decode used when registering the grant vector.
package rom_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT0,
    ARB_GRANT1
  } rom_arb_state_t;

  function automatic logic [1:0] grant_of(input rom_arb_state_t s);
    logic [1:0] g;
    case (s)
      ARB_GRANT0: g = 2'b01;
      ARB_GRANT1: g = 2'b10;
      default:    g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bundle. dat_o_s is driven by the secondary; the primary
// reads it back under the name dat_i_p.
interface wishbone_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4,
  parameter int TW = 4
) ();
  logic          cyc;
  logic          stb;
  logic          we;
  logic          ack;
  logic [TW-1:0] tgd;
  logic [SW-1:0] sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] dat_o_p;
  logic [DW-1:0] dat_o_s;
  logic [DW-1:0] dat_i_p;

  assign dat_i_p = dat_o_s;

  modport primary (
    output cyc, stb, we, tgd, sel, addr, dat_o_p,
    input  ack, dat_i_p
  );

  modport secondary (
    input  cyc, stb, we, tgd, sel, addr, dat_o_p,
    output ack, dat_o_s
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing the ROM Wishbone secondary between the
// instruction-cache (req0) and data-cache (req1) refill primaries.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  wishbone_if.secondary wish_s_req0,
  wishbone_if.secondary wish_s_req1,
  wishbone_if.primary   wish_p_rom,
  output logic [1:0]    grant
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  rom_arb_state_t state_q, state_d;
  logic           last_q, last_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]     grant_q, grant_d;

  logic req0, req1, own_is1, own_cyc, other_req;

  always_comb begin
    req0      = wish_s_req0.cyc & wish_s_req0.stb;
    req1      = wish_s_req1.cyc & wish_s_req1.stb;
    own_is1   = (state_q == ARB_GRANT1);
    own_cyc   = own_is1 ? wish_s_req1.cyc : wish_s_req0.cyc;
    other_req = own_is1 ? req0 : req1;

    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      ARB_IDLE: begin
        hold_cnt_d = '0;
        // last_q=1 after reset, so req0 wins the first tie.
        if (req0 && (!req1 || last_q)) state_d = ARB_GRANT0;
        else if (req1)                  state_d = ARB_GRANT1;
      end
      ARB_GRANT0, ARB_GRANT1: begin
        if (!own_cyc) begin
          state_d = ARB_IDLE;
        end else if (wish_p_rom.ack && other_req && (hold_cnt_q == HOLD_LAST)) begin
          state_d    = own_is1 ? ARB_GRANT0 : ARB_GRANT1;
          hold_cnt_d = '0;
        end else if (!other_req) begin
          // A lone primary is never rotated away, so only count under contention.
          hold_cnt_d = '0;
        end else if (wish_p_rom.ack && (hold_cnt_q != HOLD_LAST)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (state_d == ARB_GRANT0) last_d = 1'b0;
    if (state_d == ARB_GRANT1) last_d = 1'b1;
    grant_d = grant_of(state_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= '0;
      grant_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign grant = grant_q;

  // Datapath follows the registered state, so async reset silences the ROM at once.
  always_comb begin
    wish_p_rom.cyc     = 1'b0;
    wish_p_rom.stb     = 1'b0;
    wish_p_rom.we      = 1'b0;
    wish_p_rom.addr    = wish_s_req0.addr;
    wish_p_rom.sel     = wish_s_req0.sel;
    wish_p_rom.tgd     = wish_s_req0.tgd;
    wish_p_rom.dat_o_p = wish_s_req0.dat_o_p;
    wish_s_req0.ack    = 1'b0;
    wish_s_req1.ack    = 1'b0;
    wish_s_req0.dat_o_s = wish_p_rom.dat_i_p;
    wish_s_req1.dat_o_s = wish_p_rom.dat_i_p;

    case (state_q)
      ARB_GRANT0: begin
        wish_p_rom.cyc  = wish_s_req0.cyc;
        wish_p_rom.stb  = wish_s_req0.stb;
        wish_p_rom.we   = wish_s_req0.we;
        wish_s_req0.ack = wish_p_rom.ack;
      end
      ARB_GRANT1: begin
        wish_p_rom.cyc     = wish_s_req1.cyc;
        wish_p_rom.stb     = wish_s_req1.stb;
        wish_p_rom.we      = wish_s_req1.we;
        wish_p_rom.addr    = wish_s_req1.addr;
        wish_p_rom.sel     = wish_s_req1.sel;
        wish_p_rom.tgd     = wish_s_req1.tgd;
        wish_p_rom.dat_o_p = wish_s_req1.dat_o_p;
        wish_s_req1.ack    = wish_p_rom.ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: two scripted cache primaries, a ROM
// model with programmable ack latency, and per-cycle traces checked afterwards.
module tb_rom_access_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] grant;

  wishbone_if w0 ();
  wishbone_if w1 ();
  wishbone_if rom ();

  rom_access_arbiter #(.MAX_HOLD(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wish_s_req0 (w0),
    .wish_s_req1 (w1),
    .wish_p_rom  (rom),
    .grant       (grant)
  );

  always #5 clock = ~clock;

  // ROM model: ack rom_lat cycles after it first sees cyc&stb, one cycle wide.
  int   rom_lat = 2;
  int   rom_wait;
  logic rom_ack_r;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_wait  <= 0;
      rom_ack_r <= 1'b0;
    end else if (rom.cyc && rom.stb && !rom_ack_r) begin
      if (rom_wait >= rom_lat - 1) begin
        rom_ack_r <= 1'b1;
        rom_wait  <= 0;
      end else begin
        rom_wait <= rom_wait + 1;
      end
    end else begin
      rom_ack_r <= 1'b0;
      rom_wait  <= 0;
    end
  end
  assign rom.ack     = rom_ack_r;
  assign rom.dat_o_s = rom.addr ^ 32'hA5A5_5A5A;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle trace, sampled 1 time unit after each rising edge.
  int          n_tr;
  logic [1:0]  g_tr  [64];
  bit          a0_tr [64];
  bit          a1_tr [64];
  logic [31:0] d0_tr [64];
  logic [31:0] d1_tr [64];
  logic [31:0] ra_tr [64];
  int          n0, n1;

  task automatic clear_trace();
    n_tr = 0;
  endtask

  task automatic run_cycle();
    logic a0, a1;
    a0 = w0.ack;
    a1 = w1.ack;
    if (n_tr < 64) begin
      g_tr[n_tr]  = grant;
      a0_tr[n_tr] = a0;
      a1_tr[n_tr] = a1;
      d0_tr[n_tr] = w0.dat_i_p;
      d1_tr[n_tr] = w1.dat_i_p;
      ra_tr[n_tr] = rom.addr;
    end
    if (a0) $display("txn p0 cycle=%0d addr=%h data=%h grant=%b", n_tr, w0.addr, w0.dat_i_p, grant);
    if (a1) $display("txn p1 cycle=%0d addr=%h data=%h grant=%b", n_tr, w1.addr, w1.dat_i_p, grant);
    n_tr++;
    @(posedge clock);
    #1;
    if (a0 && n0 > 0) begin
      n0--;
      w0.addr = w0.addr + 32'd1;
      if (n0 == 0) begin w0.cyc = 1'b0; w0.stb = 1'b0; w0.we = 1'b0; end
    end
    if (a1 && n1 > 0) begin
      n1--;
      w1.addr = w1.addr + 32'd1;
      if (n1 == 0) begin w1.cyc = 1'b0; w1.stb = 1'b0; w1.we = 1'b0; end
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic start0(input int n, input logic [31:0] addr, input logic we);
    n0 = n; w0.addr = addr; w0.we = we; w0.sel = 4'hF; w0.tgd = 4'h3;
    w0.dat_o_p = 32'h1111_0000; w0.cyc = 1'b1; w0.stb = 1'b1;
  endtask

  task automatic start1(input int n, input logic [31:0] addr, input logic we);
    n1 = n; w1.addr = addr; w1.we = we; w1.sel = 4'h5; w1.tgd = 4'hC;
    w1.dat_o_p = 32'h2222_0000; w1.cyc = 1'b1; w1.stb = 1'b1;
  endtask

  task automatic idle_primaries();
    n0 = 0; n1 = 0;
    w0.cyc = 1'b0; w0.stb = 1'b0; w0.we = 1'b0;
    w1.cyc = 1'b0; w1.stb = 1'b0; w1.we = 1'b0;
  endtask

  task automatic do_reset();
    idle_primaries();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  function automatic int count_ack(input bit p1, input int from, input int to);
    int c;
    c = 0;
    for (int i = from; i < to && i < 64; i++)
      if (p1 ? a1_tr[i] : a0_tr[i]) c++;
    return c;
  endfunction

  function automatic int first_ack(input bit p1);
    for (int i = 0; i < n_tr && i < 64; i++)
      if (p1 ? a1_tr[i] : a0_tr[i]) return i;
    return -1;
  endfunction

  function automatic int first_grant(input logic [1:0] v, input int from);
    for (int i = from; i < n_tr && i < 64; i++)
      if (g_tr[i] === v) return i;
    return -1;
  endfunction

  function automatic int count_grant_ne(input logic [1:0] v, input int from, input int to);
    int c;
    c = 0;
    for (int i = from; i <= to && i < 64; i++)
      if (g_tr[i] !== v) c++;
    return c;
  endfunction

  initial begin
    int f10;
    w0.addr = '0; w0.sel = '0; w0.tgd = '0; w0.dat_o_p = '0;
    w1.addr = '0; w1.sel = '0; w1.tgd = '0; w1.dat_o_p = '0;
    idle_primaries();
    n_tr = 0;

    // Reset state, observed while reset is held.
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_rom_cyc", 32'(rom.cyc), 32'd0);
    check_eq("rst_rom_stb", 32'(rom.stb), 32'd0);
    check_eq("rst_ack0", 32'(w0.ack), 32'd0);
    check_eq("rst_ack1", 32'(w1.ack), 32'd0);

    // 1: req0 alone, ROM acks 2 cycles after stb.
    do_reset();
    rom_lat = 2;
    clear_trace();
    start0(1, 32'h0000_0100, 1'b0);
    run_n(8);
    check_eq("t1_grant_idle", 32'(g_tr[0]), 32'd0);
    check_eq("t1_first_grant", 32'(first_grant(2'b01, 0)), 32'd1);
    check_eq("t1_rom_addr", ra_tr[1], 32'h0000_0100);
    check_eq("t1_first_ack0", 32'(first_ack(1'b0)), 32'd3);
    check_eq("t1_ack0_data", d0_tr[3], 32'hA5A5_5B5A);
    check_eq("t1_ack0_total", 32'(count_ack(1'b0, 0, 8)), 32'd1);
    check_eq("t1_ack1_total", 32'(count_ack(1'b1, 0, 8)), 32'd0);
    check_eq("t1_back_idle", 32'(g_tr[5]), 32'd0);

    // 2: simultaneous requests after reset; req0 first, then req1 via IDLE.
    do_reset();
    rom_lat = 2;
    clear_trace();
    start0(1, 32'h0000_0100, 1'b0);
    start1(1, 32'h0000_0200, 1'b0);
    run_n(12);
    check_eq("t2_first_g0", 32'(first_grant(2'b01, 0)), 32'd1);
    check_eq("t2_ack0_at", 32'(first_ack(1'b0)), 32'd3);
    check_eq("t2_idle_gap", 32'(g_tr[5]), 32'd0);
    check_eq("t2_first_g1", 32'(first_grant(2'b10, 0)), 32'd6);
    check_eq("t2_ack1_at", 32'(first_ack(1'b1)), 32'd8);
    check_eq("t2_ack1_data", d1_tr[8], 32'hA5A5_585A);

    // 3: req0 streams 10 reads with req1 pending; MAX_HOLD=4 rotation.
    do_reset();
    rom_lat = 1;
    clear_trace();
    start0(10, 32'h0000_1000, 1'b0);
    start1(1, 32'h0000_2000, 1'b0);
    run_n(30);
    f10 = first_grant(2'b10, 0);
    check_eq("t3_first_g1", 32'(f10), 32'd9);
    check_eq("t3_acks_before_rot", 32'(count_ack(1'b0, 0, (f10 < 0) ? 64 : f10)), 32'd4);
    check_eq("t3_no_bubble", 32'(g_tr[8]), 32'b01);
    check_eq("t3_rom_addr_switch", ra_tr[9], 32'h0000_2000);
    check_eq("t3_back_to_g0", 32'(first_grant(2'b01, (f10 < 0) ? 0 : f10)), 32'd13);
    check_eq("t3_ack0_total", 32'(count_ack(1'b0, 0, 30)), 32'd10);
    check_eq("t3_ack1_total", 32'(count_ack(1'b1, 0, 30)), 32'd1);

    // 4: req1 alone for 20 reads is never rotated away.
    do_reset();
    rom_lat = 1;
    clear_trace();
    start1(20, 32'h0000_0800, 1'b0);
    run_n(45);
    check_eq("t4_grant_held", 32'(count_grant_ne(2'b10, 1, 41)), 32'd0);
    check_eq("t4_ack1_total", 32'(count_ack(1'b1, 0, 45)), 32'd20);
    check_eq("t4_ack0_total", 32'(count_ack(1'b0, 0, 45)), 32'd0);
    check_eq("t4_release", 32'(g_tr[42]), 32'd0);

    // 5: owner aborts before ack; pending req1 granted after one idle cycle.
    do_reset();
    rom_lat = 5;
    clear_trace();
    start0(1, 32'h0000_0500, 1'b0);
    start1(1, 32'h0000_0600, 1'b0);
    run_n(2);
    n0 = 0; w0.cyc = 1'b0; w0.stb = 1'b0;
    run_n(12);
    check_eq("t5_owner", 32'(g_tr[1]), 32'b01);
    check_eq("t5_idle", 32'(g_tr[3]), 32'd0);
    check_eq("t5_g1", 32'(g_tr[4]), 32'b10);
    check_eq("t5_no_early_ack", 32'(count_ack(1'b0, 0, 14) + count_ack(1'b1, 0, 5)), 32'd0);
    check_eq("t5_ack1_total", 32'(count_ack(1'b1, 0, 14)), 32'd1);

    // 6: async reset between stb and ack, then restart with req0 priority.
    do_reset();
    rom_lat = 3;
    clear_trace();
    start0(1, 32'h0000_0300, 1'b1);
    run_n(2);
    check_eq("t6_pre_we", 32'(rom.we), 32'd1);
    start1(1, 32'h0000_0400, 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_cyc", 32'(rom.cyc), 32'd0);
    check_eq("t6_rst_stb", 32'(rom.stb), 32'd0);
    check_eq("t6_rst_we", 32'(rom.we), 32'd0);
    check_eq("t6_rst_acks", 32'({w1.ack, w0.ack}), 32'd0);
    check_eq("t6_rst_grant", 32'(grant), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    clear_trace();
    run_n(12);
    check_eq("t6_restart_g0", 32'(g_tr[1]), 32'b01);
    check_eq("t6_ack0_at", 32'(first_ack(1'b0)), 32'd4);
    check_eq("t6_then_g1", 32'(first_grant(2'b10, 0)), 32'd7);
    check_eq("t6_ack1_total", 32'(count_ack(1'b1, 0, 12)), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
